// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//
// MM:SS countdown timer kept as four BCD digits. Each rising edge of
// count_clock is one tick (one second of countdown while running).
//
// Operating modes:
//   IDLE    - the preset is adjusted with adj/sel; start begins the countdown
//   RUN     - the value drops by one second per tick
//   PAUSED  - the value is held; pause resumes the countdown
//   EXPIRED - the value is 00:00 and alarm is high for ALARM_TICKS ticks;
//             start or clear acknowledges and returns to IDLE
//
// Input priority on every edge: clear > adj > start > pause.
// adj acts only in IDLE.
//
// Parameters:
//   ALARM_TICKS - number of ticks alarm stays high after expiry (1..255)
//
// Ports:
//   count_clock - rising-edge clock, one tick per edge
//   rst         - asynchronous active-high reset
//   start       - start from IDLE, or acknowledge expiry from EXPIRED
//   pause       - toggle between RUN and PAUSED
//   clear       - abort to IDLE with value 00:00
//   adj         - preset-adjust enable (IDLE only)
//   sel         - adjust target: 0 = seconds, 1 = minutes
//   min1..sec0  - BCD digits of the remaining time, MM:SS
//   state       - IDLE=0, RUN=1, PAUSED=2, EXPIRED=3
//   running     - state is RUN (registered)
//   expired     - state is EXPIRED (registered)
//   alarm       - alarm window after expiry (registered)
// -----------------------------------------------------------------------------
module countdown_timer #(
  parameter int unsigned ALARM_TICKS = 10
) (
  input  logic       count_clock,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] min1,
  output logic [3:0] min0,
  output logic [3:0] sec1,
  output logic [3:0] sec0,
  output logic [1:0] state,
  output logic       running,
  output logic       expired,
  output logic       alarm
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  // The expiry edge itself is the first alarm-high tick, so the counter
  // only has to cover the remaining ALARM_TICKS-1 ticks.
  localparam logic [7:0] ALARM_LOAD = 8'(ALARM_TICKS - 32'd1);

  // Time value packed as {min1, min0, sec1, sec0}.
  localparam logic [15:0] TIME_ZERO = 16'h0000;

  // Increment one BCD digit that wraps after top. Returns {carry, digit}.
  // A digit at or above top wraps to 0, so an illegal digit self-corrects.
  function automatic logic [4:0] digit_inc(input logic [3:0] d, input logic [3:0] top);
    logic [4:0] r;
    if (d >= top) begin
      r = {1'b1, 4'd0};
    end else begin
      r = {1'b0, d + 4'd1};
    end
    return r;
  endfunction

  // Decrement one BCD digit that reloads with top. Returns {borrow, digit}.
  function automatic logic [4:0] digit_dec(input logic [3:0] d, input logic [3:0] top);
    logic [4:0] r;
    if (d == 4'd0) begin
      r = {1'b1, top};
    end else begin
      r = {1'b0, d - 4'd1};
    end
    return r;
  endfunction

  // Seconds field +1, wrapping 59 -> 00 with no carry into minutes.
  function automatic logic [15:0] sec_inc(input logic [15:0] t);
    logic [4:0]  lo;
    logic [4:0]  hi;
    logic [15:0] r;
    lo = digit_inc(t[3:0], 4'd9);
    hi = digit_inc(t[7:4], 4'd5);
    r  = t;
    r[3:0] = lo[3:0];
    if (lo[4]) begin
      r[7:4] = hi[3:0];
    end else begin
      r[7:4] = t[7:4];
    end
    return r;
  endfunction

  // Minutes field +1, wrapping 99 -> 00; seconds unchanged.
  function automatic logic [15:0] min_inc(input logic [15:0] t);
    logic [4:0]  lo;
    logic [4:0]  hi;
    logic [15:0] r;
    lo = digit_inc(t[11:8], 4'd9);
    hi = digit_inc(t[15:12], 4'd9);
    r  = t;
    r[11:8] = lo[3:0];
    if (lo[4]) begin
      r[15:12] = hi[3:0];
    end else begin
      r[15:12] = t[15:12];
    end
    return r;
  endfunction

  // Whole value -1 second with the BCD borrow chain
  // sec0 -> sec1 -> min0 -> min1. Never called with 00:00 in normal use.
  function automatic logic [15:0] time_dec(input logic [15:0] t);
    logic [4:0]  d0;
    logic [4:0]  d1;
    logic [4:0]  d2;
    logic [4:0]  d3;
    logic [15:0] r;
    d0 = digit_dec(t[3:0],   4'd9);
    d1 = digit_dec(t[7:4],   4'd5);
    d2 = digit_dec(t[11:8],  4'd9);
    d3 = digit_dec(t[15:12], 4'd9);
    r  = t;
    r[3:0] = d0[3:0];
    if (d0[4]) begin
      r[7:4] = d1[3:0];
      if (d1[4]) begin
        r[11:8] = d2[3:0];
        if (d2[4]) begin
          r[15:12] = d3[3:0];
        end else begin
          r[15:12] = t[15:12];
        end
      end else begin
        r[11:8] = t[11:8];
      end
    end else begin
      r[7:4] = t[7:4];
    end
    return r;
  endfunction

  state_e      state_q,     state_d;
  logic [15:0] time_q,      time_d;
  logic [7:0]  alarm_cnt_q, alarm_cnt_d;
  logic        alarm_q,     alarm_d;
  logic        running_q,   running_d;
  logic        expired_q,   expired_d;
  logic [15:0] time_dec_s;

  assign time_dec_s = time_dec(time_q);

  // Next-state, next-value and alarm window logic.
  always_comb begin
    state_d     = state_q;
    time_d      = time_q;
    alarm_cnt_d = alarm_cnt_q;
    alarm_d     = alarm_q;

    case (state_q)
      ST_IDLE: begin
        alarm_d     = 1'b0;
        alarm_cnt_d = 8'd0;
        if (clear) begin
          time_d = TIME_ZERO;
        end else if (adj) begin
          if (sel) begin
            time_d = min_inc(time_q);
          end else begin
            time_d = sec_inc(time_q);
          end
        end else if (start) begin
          // Starting with nothing on the clock would expire immediately;
          // refuse it and stay idle.
          if (time_q != TIME_ZERO) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (clear) begin
          state_d = ST_IDLE;
          time_d  = TIME_ZERO;
        end else if (pause) begin
          state_d = ST_PAUSED;
        end else if (time_q == TIME_ZERO) begin
          // Unreachable in normal use; expire instead of wrapping to 99:59.
          state_d     = ST_EXPIRED;
          alarm_d     = 1'b1;
          alarm_cnt_d = ALARM_LOAD;
        end else begin
          time_d = time_dec_s;
          // The edge that reaches 00:00 is also the first alarm tick.
          if (time_dec_s == TIME_ZERO) begin
            state_d     = ST_EXPIRED;
            alarm_d     = 1'b1;
            alarm_cnt_d = ALARM_LOAD;
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_PAUSED: begin
        if (clear) begin
          state_d = ST_IDLE;
          time_d  = TIME_ZERO;
        end else if (pause) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PAUSED;
        end
      end

      ST_EXPIRED: begin
        time_d = TIME_ZERO;
        if (clear || start) begin
          state_d     = ST_IDLE;
          alarm_d     = 1'b0;
          alarm_cnt_d = 8'd0;
        end else if (alarm_cnt_q != 8'd0) begin
          alarm_d     = 1'b1;
          alarm_cnt_d = alarm_cnt_q - 8'd1;
        end else begin
          alarm_d     = 1'b0;
          alarm_cnt_d = 8'd0;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        time_d      = TIME_ZERO;
        alarm_d     = 1'b0;
        alarm_cnt_d = 8'd0;
      end
    endcase

    // Status flags are registered copies of the next state so they
    // have no combinational path from any input.
    running_d = (state_d == ST_RUN);
    expired_d = (state_d == ST_EXPIRED);
  end

  // State, time value, alarm counter and status flags.
  always_ff @(posedge count_clock or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      time_q      <= TIME_ZERO;
      alarm_cnt_q <= 8'd0;
      alarm_q     <= 1'b0;
      running_q   <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      time_q      <= time_d;
      alarm_cnt_q <= alarm_cnt_d;
      alarm_q     <= alarm_d;
      running_q   <= running_d;
      expired_q   <= expired_d;
    end
  end

  assign min1    = time_q[15:12];
  assign min0    = time_q[11:8];
  assign sec1    = time_q[7:4];
  assign sec0    = time_q[3:0];
  assign state   = state_q;
  assign running = running_q;
  assign expired = expired_q;
  assign alarm   = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer
//
// Self-checking bench for countdown_timer (built with ALARM_TICKS=3):
// a table of single-edge vectors, hand-written multi-cycle sequences, and a
// randomized run compared against a seconds-count reference model.
// -----------------------------------------------------------------------------
module tb_countdown_timer;

  localparam int AT = 3;

  logic       count_clock = 1'b0;
  logic       rst;
  logic       start, pause, clear, adj, sel;
  logic [3:0] min1, min0, sec1, sec0;
  logic [1:0] state;
  logic       running, expired, alarm;

  int checks   = 0;
  int failures = 0;

  // Reference model: remaining time as plain seconds, mode number,
  // and alarm ticks still to be shown.
  int m_secs;
  int m_mode;
  int m_alarm_left;

  countdown_timer #(.ALARM_TICKS(AT)) dut (
    .count_clock (count_clock),
    .rst         (rst),
    .start       (start),
    .pause       (pause),
    .clear       (clear),
    .adj         (adj),
    .sel         (sel),
    .min1        (min1),
    .min0        (min0),
    .sec1        (sec1),
    .sec0        (sec0),
    .state       (state),
    .running     (running),
    .expired     (expired),
    .alarm       (alarm)
  );

  always #5 count_clock = ~count_clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Compare all outputs against expected BCD time (16'hMMSS), state, alarm.
  task automatic check_out(input string name, input logic [15:0] et,
                           input logic [1:0] es, input logic eal);
    logic [20:0] act;
    logic [20:0] req;
    act = {min1, min0, sec1, sec0, state, running, expired, alarm};
    req = {et, es, (es == 2'd1), (es == 2'd3), eal};
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got time=%h state=%0d run=%b exp=%b alarm=%b, want time=%h state=%0d run=%b exp=%b alarm=%b",
               name, act[20:5], act[4:3], act[2], act[1], act[0],
               req[20:5], req[4:3], req[2], req[1], req[0]);
    end
  endtask

  // Apply inputs, let one edge happen, settle just after it.
  task automatic drive(input logic c, input logic a, input logic sl,
                       input logic st, input logic p);
    clear = c; adj = a; sel = sl; start = st; pause = p;
    @(posedge count_clock);
    #1;
  endtask

  task automatic idle_edges(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic adj_edges(input logic sl, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, sl, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    m_secs = 0; m_mode = 0; m_alarm_left = 0;
  endtask

  // Expected time in BCD from the model's seconds count.
  function automatic logic [15:0] model_bcd();
    int mm;
    int ss;
    mm = m_secs / 60;
    ss = m_secs % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  // One tick of the reference model.
  task automatic model_step(input logic c, input logic a, input logic sl,
                            input logic st, input logic p);
    case (m_mode)
      0: begin
        if (c) m_secs = 0;
        else if (a) begin
          if (sl) m_secs = (((m_secs / 60) + 1) % 100) * 60 + (m_secs % 60);
          else    m_secs = (m_secs / 60) * 60 + ((m_secs % 60) + 1) % 60;
        end
        else if (st && m_secs != 0) m_mode = 1;
      end
      1: begin
        if (c) begin m_mode = 0; m_secs = 0; end
        else if (p) m_mode = 2;
        else begin
          m_secs = m_secs - 1;
          if (m_secs == 0) begin m_mode = 3; m_alarm_left = AT; end
        end
      end
      2: begin
        if (c) begin m_mode = 0; m_secs = 0; end
        else if (p) m_mode = 1;
      end
      default: begin
        if (c || st) begin m_mode = 0; m_alarm_left = 0; end
        else if (m_alarm_left > 0) m_alarm_left = m_alarm_left - 1;
      end
    endcase
  endtask

  typedef struct {
    logic        c, a, sl, st, p;
    logic [15:0] et;
    logic [1:0]  es;
    logic        eal;
  } vec_t;

  vec_t tbl[22];

  initial begin
    rst = 1'b1;
    start = 1'b0; pause = 1'b0; clear = 1'b0; adj = 1'b0; sel = 1'b0;
    m_secs = 0; m_mode = 0; m_alarm_left = 0;

    //          c     a     sl    st    p     time      st    alarm
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 2'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0002, 2'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0102, 2'd0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0102, 2'd1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0101, 2'd1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0101, 2'd2, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0101, 2'd2, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0101, 2'd2, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0101, 2'd1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0100, 2'd1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0059, 2'd1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 2'd0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 2'd0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0001, 2'd1, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd3, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd3, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd3, 1'b1};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd3, 1'b0};
    tbl[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 2'd3, 1'b0};
    tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0};
    tbl[21] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0};

    // Reset state while rst is held
    #12;
    check_out("reset", 16'h0000, 2'd0, 1'b0);
    @(negedge count_clock);
    rst = 1'b0;

    // Table-driven single-edge vectors
    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].c, tbl[i].a, tbl[i].sl, tbl[i].st, tbl[i].p);
      check_out($sformatf("vec%0d", i), tbl[i].et, tbl[i].es, tbl[i].eal);
    end

    // Preset 12:05 via adj, run 725 s to expiry
    adj_edges(1'b1, 12);
    adj_edges(1'b0, 5);
    check_out("preset_1205", 16'h1205, 2'd0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_out("start_1205", 16'h1205, 2'd1, 1'b0);
    idle_edges(724);
    check_out("run_724", 16'h0001, 2'd1, 1'b0);
    idle_edges(1);
    check_out("expire_725", 16'h0000, 2'd3, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_out("ack_1205", 16'h0000, 2'd0, 1'b0);

    // Borrow chains
    adj_edges(1'b1, 10);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_edges(1);
    check_out("borrow_1000", 16'h0959, 2'd1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out("clear_run", 16'h0000, 2'd0, 1'b0);
    adj_edges(1'b1, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_edges(1);
    check_out("borrow_0100", 16'h0059, 2'd1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Pause holds across 7 edges, resume without decrement
    adj_edges(1'b0, 30);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_out("pause_enter", 16'h0030, 2'd2, 1'b0);
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_out("pause_hold", 16'h0030, 2'd2, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_out("pause_resume", 16'h0030, 2'd1, 1'b0);
    idle_edges(1);
    check_out("pause_next", 16'h0029, 2'd1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Wraps and priority
    adj_edges(1'b1, 3);
    adj_edges(1'b0, 59);
    check_out("sec_59", 16'h0359, 2'd0, 1'b0);
    adj_edges(1'b0, 1);
    check_out("sec_wrap", 16'h0300, 2'd0, 1'b0);
    adj_edges(1'b1, 96);
    check_out("min_99", 16'h9900, 2'd0, 1'b0);
    adj_edges(1'b1, 1);
    check_out("min_wrap", 16'h0000, 2'd0, 1'b0);
    adj_edges(1'b1, 1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check_out("prio_clear", 16'h0000, 2'd0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_out("start_zero", 16'h0000, 2'd0, 1'b0);

    // Asynchronous reset mid-RUN at 05:17
    adj_edges(1'b1, 5);
    adj_edges(1'b0, 17);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_out("run_0517", 16'h0517, 2'd1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_out("async_rst", 16'h0000, 2'd0, 1'b0);
    start = 1'b0;
    @(posedge count_clock);
    #1;
    check_out("rst_held", 16'h0000, 2'd0, 1'b0);
    rst = 1'b0;
    idle_edges(1);
    check_out("post_rst", 16'h0000, 2'd0, 1'b0);

    // Randomized run against the reference model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic c, a, sl, st, p;
      c  = ($urandom % 40) == 0;
      a  = ($urandom % 4) == 0;
      sl = ($urandom % 5) == 0;
      st = ($urandom % 6) == 0;
      p  = ($urandom % 10) == 0;
      if (($urandom % 300) == 0) begin
        #2;
        rst = 1'b1;
        m_secs = 0; m_mode = 0; m_alarm_left = 0;
        #1;
        check_out("rand_rst", 16'h0000, 2'd0, 1'b0);
        #2;
        rst = 1'b0;
      end
      drive(c, a, sl, st, p);
      model_step(c, a, sl, st, p);
      check_out("rand", model_bcd(), 2'(m_mode), (m_mode == 3) && (m_alarm_left > 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
